uart_tx_serializer: RTL and testbench

Transmit serializer of the 16550 UART: pops bytes from the TX FIFO, then shifts each out on `txd` as an asynchronous serial frame. A frame is start bit, 5–8 data bits LSB first, optional parity, then 1/1.5/2 stop bits. Bit timing comes from a 16x oversampling baud tick supplied by the baud generator. Line-control fields come straight from the LCR register.

---
 rtl/uart_tx_serializer_if.sv | 32 +++
 rtl/uart_tx_serializer.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Handshake/bus bundle for uart_tx_serializer: TX FIFO pop port, LCR fields,
// baud strobe and the serial line/status outputs.
interface uart_tx_serializer_if;
    logic       baud_tick;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_valid;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       stick_par;
    logic       break_ctrl;
    logic       txd;
    logic       tx_busy;
    logic       tx_empty;

    // Serializer side.
    modport master (
        input  baud_tick, fifo_empty, fifo_rd_data, fifo_rd_valid,
        input  wls, stb, pen, eps, stick_par, break_ctrl,
        output fifo_rd_en, txd, tx_busy, tx_empty
    );

    // FIFO / LCR / line-observer side.
    modport slave (
        output baud_tick, fifo_empty, fifo_rd_data, fifo_rd_valid,
        output wls, stb, pen, eps, stick_par, break_ctrl,
        input  fifo_rd_en, txd, tx_busy, tx_empty
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// 16550-style transmit serializer: pops a byte from the TX FIFO and shifts it
// out as start + 5..8 data bits (LSB first) + optional parity + 1/1.5/2 stops.
// Bit timing counts TICKS_PER_BIT baud strobes per bit.
// Optional feature: define UART_TX_BREAK_EN to let break_ctrl force txd low.
module uart_tx_serializer #(
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.master tx_if
);

    localparam int unsigned CntW = $clog2(2 * TICKS_PER_BIT + 1);
    localparam logic [CntW-1:0] TicksOne  = CntW'(TICKS_PER_BIT);
    localparam logic [CntW-1:0] TicksOneH = CntW'(TICKS_PER_BIT * 3 / 2);
    localparam logic [CntW-1:0] TicksTwo  = CntW'(2 * TICKS_PER_BIT);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic [1:0]      r_wls;
    logic            r_stb;
    logic            r_pen;
    logic            r_eps;
    logic            r_stick;
    logic            r_txd;

    logic [CntW-1:0] w_tick_limit;
    logic            w_bit_done;
    logic            w_last_data;
    logic [7:0]      w_data_mask;
    logic            w_par_xor;
    logic            w_par_bit;
    logic            w_rd_en;

    // Bit-length, end-of-bit, parity and pop-request decode.
    always_comb begin
        w_tick_limit = TicksOne;
        if (r_state == StStop && r_stb) begin
            w_tick_limit = (r_wls == 2'b00) ? TicksOneH : TicksTwo;
        end
        w_bit_done  = tx_if.baud_tick && (r_tick_cnt == w_tick_limit - CntW'(1));
        w_last_data = (r_bit_cnt == {1'b0, r_wls} + 3'd4);
        // Only the wls+5 transmitted bits take part in parity.
        w_data_mask = 8'hFF >> (2'd3 - r_wls);
        w_par_xor   = ^(r_data & w_data_mask);
        w_par_bit   = r_stick ? ~r_eps : (r_eps ? w_par_xor : ~w_par_xor);
        w_rd_en     = (r_state == StIdle) && !tx_if.fifo_empty && !rst;
    end

    // Frame FSM; txd is loaded with the level of the bit being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_wls      <= '0;
            r_stb      <= 1'b0;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_stick    <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            // Ticks only count inside a bit; a bit's last tick clears the count.
            if (r_state == StIdle || r_state == StFetch) begin
                r_tick_cnt <= '0;
            end else if (tx_if.baud_tick) begin
                r_tick_cnt <= w_bit_done ? '0 : r_tick_cnt + CntW'(1);
            end

            case (r_state)
                StIdle: begin
                    r_txd <= 1'b1;
                    if (w_rd_en) begin
                        r_state <= StFetch;
                    end
                end
                StFetch: begin
                    if (tx_if.fifo_rd_valid) begin
                        r_shift <= tx_if.fifo_rd_data;
                        r_data  <= tx_if.fifo_rd_data;
                        r_wls   <= tx_if.wls;
                        r_stb   <= tx_if.stb;
                        r_pen   <= tx_if.pen;
                        r_eps   <= tx_if.eps;
                        r_stick <= tx_if.stick_par;
                        r_state <= StStart;
                        r_txd   <= 1'b0;
                    end
                end
                StStart: begin
                    if (w_bit_done) begin
                        r_state   <= StData;
                        r_bit_cnt <= '0;
                        r_txd     <= r_shift[0];
                    end
                end
                StData: begin
                    if (w_bit_done) begin
                        if (w_last_data) begin
                            r_state <= r_pen ? StParity : StStop;
                            r_txd   <= r_pen ? w_par_bit : 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end
                end
                StParity: begin
                    if (w_bit_done) begin
                        r_state <= StStop;
                        r_txd   <= 1'b1;
                    end
                end
                StStop: begin
                    if (w_bit_done) begin
                        r_state <= StIdle;
                        r_txd   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign tx_if.fifo_rd_en = w_rd_en;
    assign tx_if.tx_busy    = (r_state != StIdle);
    assign tx_if.tx_empty   = tx_if.fifo_empty && (r_state == StIdle);

`ifdef UART_TX_BREAK_EN
    logic r_brk;

    // Break is registered so txd stays free of combinational input paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brk <= 1'b0;
        end else begin
            r_brk <= tx_if.break_ctrl;
        end
    end

    assign tx_if.txd = r_txd & ~r_brk;
`else
    logic w_unused_break;
    assign w_unused_break = tx_if.break_ctrl;
    assign tx_if.txd      = r_txd;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: captures txd once per baud tick
// during each frame and compares against hand-written vectors and a
// frame-level reference model.
module tb_uart_tx_serializer;

    localparam int TPB = 16;

    typedef struct {
        logic [255:0] bits;
        int           len;
        int           start_cyc;
        int           last_tick_cyc;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  wls;
        logic        stb;
        logic        pen;
        logic        eps;
        logic        stick;
        logic [11:0] exp_lv;   // level of each bit before the stop, start first
        int          exp_n;
        int          exp_stop; // stop length in ticks
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    uart_tx_serializer_if bus ();

    uart_tx_serializer #(.TICKS_PER_BIT(TPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    frame_t     frames[$];
    frame_t     cur;
    bit         in_frame  = 1'b0;
    bit         mon_off   = 1'b0;
    int         cyc       = 0;
    int         rd_en_cnt = 0;
    int         tick_div  = 2;
    int         errors    = 0;
    int         checks    = 0;

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_frame(input string name, input frame_t got, input frame_t exp);
        checks++;
        if (got.len != exp.len || got.bits !== exp.bits) begin
            errors++;
            $display("FAIL %s: got len=%0d ticks=%h expected len=%0d ticks=%h",
                     name, got.len, got.bits, exp.len, exp.bits);
        end
    endtask

    // Expand per-bit levels into the per-tick txd stream of one frame.
    function automatic frame_t expand(input logic [11:0] lv, input int n, input int stop_ticks);
        frame_t r;
        r.bits = '0;
        r.len  = 0;
        r.start_cyc = 0;
        r.last_tick_cyc = 0;
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < TPB; t++) begin
                r.bits[r.len] = lv[i];
                r.len++;
            end
        end
        for (int t = 0; t < stop_ticks; t++) begin
            r.bits[r.len] = 1'b1;
            r.len++;
        end
        return r;
    endfunction

    // Reference: frame for one byte under a given line control setting.
    function automatic frame_t ref_frame(input logic [7:0] d, input logic [1:0] wls,
                                         input logic stb, input logic pen,
                                         input logic eps, input logic stick);
        logic [11:0] lv;
        int nd, n, ones, stop;
        nd   = 5 + int'(wls);
        lv   = '0;
        n    = 1;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            lv[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pen) begin
            if (stick) lv[n] = !eps;
            else       lv[n] = eps ? (ones % 2 == 1) : (ones % 2 == 0);
            n++;
        end
        stop = !stb ? TPB : (nd == 5 ? TPB * 3 / 2 : 2 * TPB);
        return expand(lv, n, stop);
    endfunction

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_int({name, "_arrived"}, int'(frames.size() >= n), 1);
    endtask

    task automatic set_lcr(input logic [1:0] wls, input logic stb, input logic pen,
                           input logic eps, input logic stick);
        bus.wls       = wls;
        bus.stb       = stb;
        bus.pen       = pen;
        bus.eps       = eps;
        bus.stick_par = stick;
    endtask

    // FIFO + baud strobe driver: inputs change 1 time unit after the rising edge.
    initial begin
        bit pop;
        int div = 0;
        bus.baud_tick     = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_rd_valid = 1'b0;
        bus.fifo_rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            pop = bus.fifo_rd_en;
            @(posedge clk);
            #1;
            div++;
            bus.baud_tick = (div % tick_div == 0);
            if (pop && fifo_q.size() > 0) begin
                bus.fifo_rd_data  = fifo_q.pop_front();
                bus.fifo_rd_valid = 1'b1;
            end else begin
                bus.fifo_rd_valid = 1'b0;
            end
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Line monitor: one txd sample per baud tick from the start bit until idle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (bus.fifo_rd_en) rd_en_cnt++;
                if (!in_frame && !mon_off && bus.tx_busy && bus.txd == 1'b0) begin
                    in_frame      = 1'b1;
                    cur.bits      = '0;
                    cur.len       = 0;
                    cur.start_cyc = cyc;
                end
                if (in_frame) begin
                    if (!bus.tx_busy) begin
                        frames.push_back(cur);
                        in_frame = 1'b0;
                    end else if (bus.baud_tick && cur.len < 256) begin
                        cur.bits[cur.len] = bus.txd;
                        cur.len++;
                        cur.last_tick_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[8];
        frame_t f, f2;
        int     base, k;

        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h14A, 9, 16};   // 8N1
        vecs[1] = '{8'h35, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h16A, 9, 16};   // 7O1
        vecs[2] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h03E, 6, 24};   // 5N1.5
        vecs[3] = '{8'h1F, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 12'h03E, 9, 32};   // 8N2
        vecs[4] = '{8'h01, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 12'h002, 10, 16};  // stick, eps=1
        vecs[5] = '{8'h01, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 12'h202, 10, 16};  // stick, eps=0
        vecs[6] = '{8'h03, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 12'h006, 10, 16};  // 8E1
        vecs[7] = '{8'h41, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h082, 8, 16};   // 6E1, bit 6 masked

        rst            = 1'b1;
        bus.break_ctrl = 1'b0;
        set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_txd", bus.txd, 1);
        check_int("reset_rd_en", bus.fifo_rd_en, 0);
        check_int("reset_busy", bus.tx_busy, 0);
        check_int("reset_tx_empty", bus.tx_empty, 1);

        // A byte waiting during reset is neither popped nor reported as empty.
        fifo_q.push_back(8'h77);
        repeat (2) @(posedge clk);
        #1;
        check_int("reset_rd_en_held", bus.fifo_rd_en, 0);
        check_int("reset_tx_empty_fifo", bus.tx_empty, 0);
        rst = 1'b0;
        wait_frames(1, 3000, "post_reset");
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check_frame("post_reset_frame", f, ref_frame(8'h77, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            set_lcr(vecs[i].wls, vecs[i].stb, vecs[i].pen, vecs[i].eps, vecs[i].stick);
            fifo_q.push_back(vecs[i].data);
            wait_frames(1, 3000, $sformatf("vec%0d", i));
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check_frame($sformatf("vec%0d_frame", i), f,
                            expand(vecs[i].exp_lv, vecs[i].exp_n, vecs[i].exp_stop));
            end
            @(negedge clk);
            check_int($sformatf("vec%0d_tx_empty", i), bus.tx_empty, 1);
        end

        // Back-to-back: next start bit 3 clocks after the final stop tick.
        @(posedge clk);
        #1;
        set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        base = rd_en_cnt;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        wait_frames(2, 6000, "b2b");
        if (frames.size() > 1) begin
            f  = frames.pop_front();
            f2 = frames.pop_front();
            check_frame("b2b_frame0", f, ref_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
            check_frame("b2b_frame1", f2, ref_frame(8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
            check_int("b2b_gap", f2.start_cyc - f.last_tick_cyc, 3);
        end
        check_int("b2b_pops", rd_en_cnt - base, 2);

        // Random frames; LCR is scrambled mid-frame and must not matter.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic [1:0] w;
            logic       s, p, e, st;
            @(posedge clk);
            #1;
            tick_div = int'($urandom_range(1, 3));
            d  = 8'($urandom);
            w  = 2'($urandom);
            s  = 1'($urandom);
            p  = 1'($urandom);
            e  = 1'($urandom);
            st = 1'($urandom);
            set_lcr(w, s, p, e, st);
            fifo_q.push_back(d);
            k = 0;
            while (!bus.tx_busy && k < 50) begin
                @(posedge clk);
                k++;
            end
            repeat ($urandom_range(5, 100)) @(posedge clk);
            #1;
            set_lcr(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            wait_frames(1, 3000, $sformatf("rnd%0d", i));
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check_frame($sformatf("rnd%0d_frame d=%h wls=%0d stb=%0d pen=%0d eps=%0d stick=%0d",
                                      i, d, w, s, p, e, st), f, ref_frame(d, w, s, p, e, st));
            end
        end

        // Reset during data bit 3, then a fresh frame with no partial resume.
        @(posedge clk);
        #1;
        tick_div = 2;
        set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_q.push_back(8'hC3);
        k = 0;
        while (!(in_frame && cur.len >= 70) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check_int("rst_reached_bit3", int'(in_frame && cur.len >= 70), 1);
        #3;
        rst = 1'b1;
        #1;
        check_int("rst_mid_txd", bus.txd, 1);
        check_int("rst_mid_busy", bus.tx_busy, 0);
        fifo_q.push_back(8'h5A);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_frames(1, 3000, "rst_fresh");
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check_frame("rst_fresh_frame", f, ref_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        repeat (100) @(posedge clk);
        check_int("rst_no_extra_frames", frames.size(), 0);

`ifdef UART_TX_BREAK_EN
        // Break holds the line low while the FIFO still drains.
        begin
            int high_cnt = 0;
            @(posedge clk);
            #1;
            mon_off = 1'b1;
            bus.break_ctrl = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            base = rd_en_cnt;
            fifo_q.push_back(8'hFF);
            fifo_q.push_back(8'h81);
            k = 0;
            while ((fifo_q.size() > 0 || bus.tx_busy || !bus.fifo_empty || k < 10) && k < 6000) begin
                @(negedge clk);
                if (bus.txd !== 1'b0) high_cnt++;
                k++;
            end
            check_int("brk_txd_high_cycles", high_cnt, 0);
            check_int("brk_pops", rd_en_cnt - base, 2);
            @(posedge clk);
            #1;
            bus.break_ctrl = 1'b0;
            @(posedge clk);
            #1;
            check_int("brk_release_txd", bus.txd, 1);
            mon_off = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
